// File: rtl/bht_btb_lookup.sv
// BHT/BTB table reader: arbitrates the single synchronous read port between fetch
// lookups and update read-modify-write reads, decodes entries and registers results.
module bht_btb_lookup #(
  parameter int PC_BITS    = 11,
  parameter int INDEX_BITS = 6,
  parameter int TAG_BITS   = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fetch_valid,
  input  logic [PC_BITS-1:0]    fetch_pc,
  output logic                  fetch_ready,
  input  logic                  stall,
  input  logic                  upd_req,
  input  logic [PC_BITS-1:0]    upd_pc,
  output logic                  upd_ack,
  output logic [1:0]            upd_prev_counter,
  output logic                  upd_prev_valid,
  output logic                  mem_rd_en,
  output logic [INDEX_BITS-1:0] mem_rd_addr,
  input  logic [31:0]           mem_rd_data,
  input  logic                  mem_wr_en,
  input  logic [INDEX_BITS-1:0] mem_wr_addr,
  input  logic [31:0]           mem_wr_data,
  output logic                  pred_valid,
  output logic [PC_BITS-1:0]    pred_pc,
  output logic                  pred_hit,
  output logic                  pred_taken,
  output logic [PC_BITS-1:0]    pred_target
);

  localparam int TAG_LSB   = PC_BITS;
  localparam int VALID_BIT = PC_BITS + TAG_BITS;
  localparam int CNT_LSB   = VALID_BIT + 1;

  typedef enum logic [1:0] {INF_NONE, INF_FETCH, INF_UPD} infl_e;
  typedef enum logic {PRIO_UPD, PRIO_FETCH} prio_e;

  infl_e               infl_q, infl_d;
  prio_e               prio_q, prio_d;
  logic [PC_BITS-1:0]  infl_pc_q, infl_pc_d;
  logic                upd_ack_q, upd_ack_d;
  logic [1:0]          prev_cnt_q, prev_cnt_d;
  logic                prev_valid_q, prev_valid_d;
  logic                pv_q, pv_d;
  logic [PC_BITS-1:0]  ppc_q, ppc_d;
  logic                phit_q, phit_d;
  logic                ptaken_q, ptaken_d;
  logic [PC_BITS-1:0]  ptgt_q, ptgt_d;

  logic                upd_cand, pick_upd, pick_fetch;
  logic [PC_BITS-1:0]  issue_pc;
  logic [31:0]         word;
  logic [1:0]          word_cnt;
  logic                hit;

  // Issue stage; gated by rst_n so no strobe escapes while reset is held.
  always_comb begin
    upd_cand   = upd_req && (infl_q != INF_UPD) && !upd_ack_q;
    pick_upd   = 1'b0;
    pick_fetch = 1'b0;
    if (rst_n && !stall) begin
      if (upd_cand && fetch_valid) begin
        if (prio_q == PRIO_UPD) pick_upd = 1'b1;
        else                    pick_fetch = 1'b1;
      end else if (upd_cand) begin
        pick_upd = 1'b1;
      end else if (fetch_valid) begin
        pick_fetch = 1'b1;
      end
    end
    issue_pc    = pick_upd ? upd_pc : fetch_pc;
    mem_rd_en   = pick_upd | pick_fetch;
    mem_rd_addr = mem_rd_en ? issue_pc[INDEX_BITS-1:0] : '0;
    fetch_ready = pick_fetch;
  end

  // Return stage with write-first forwarding from the snooped write port.
  always_comb begin
    word = (mem_wr_en && (mem_wr_addr == infl_pc_q[INDEX_BITS-1:0])) ? mem_wr_data : mem_rd_data;
    word_cnt = word[CNT_LSB +: 2];
    hit = word[VALID_BIT] && (word[TAG_LSB +: TAG_BITS] == infl_pc_q[PC_BITS-1:INDEX_BITS]);
  end

  always_comb begin
    infl_d       = INF_NONE;
    prio_d       = prio_q;
    infl_pc_d    = infl_pc_q;
    upd_ack_d    = (infl_q == INF_UPD);
    prev_cnt_d   = prev_cnt_q;
    prev_valid_d = prev_valid_q;
    pv_d         = pv_q;
    ppc_d        = ppc_q;
    phit_d       = phit_q;
    ptaken_d     = ptaken_q;
    ptgt_d       = ptgt_q;

    if (pick_upd) begin
      infl_d    = INF_UPD;
      infl_pc_d = issue_pc;
      prio_d    = PRIO_FETCH;
    end else if (pick_fetch) begin
      infl_d    = INF_FETCH;
      infl_pc_d = issue_pc;
      prio_d    = PRIO_UPD;
    end

    if (infl_q == INF_UPD) begin
      prev_cnt_d   = hit ? word_cnt : 2'b01;
      prev_valid_d = hit;
    end

    // A fetch result always registers, even under stall; only the clear is frozen.
    if (infl_q == INF_FETCH) begin
      pv_d     = 1'b1;
      ppc_d    = infl_pc_q;
      phit_d   = hit;
      ptaken_d = hit && word_cnt[1];
      ptgt_d   = (hit && word_cnt[1]) ? word[PC_BITS-1:0]
                                      : infl_pc_q + {{(PC_BITS-1){1'b0}}, 1'b1};
    end else if (!stall) begin
      pv_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      infl_q       <= INF_NONE;
      prio_q       <= PRIO_UPD;
      infl_pc_q    <= '0;
      upd_ack_q    <= 1'b0;
      prev_cnt_q   <= '0;
      prev_valid_q <= 1'b0;
      pv_q         <= 1'b0;
      ppc_q        <= '0;
      phit_q       <= 1'b0;
      ptaken_q     <= 1'b0;
      ptgt_q       <= '0;
    end else begin
      infl_q       <= infl_d;
      prio_q       <= prio_d;
      infl_pc_q    <= infl_pc_d;
      upd_ack_q    <= upd_ack_d;
      prev_cnt_q   <= prev_cnt_d;
      prev_valid_q <= prev_valid_d;
      pv_q         <= pv_d;
      ppc_q        <= ppc_d;
      phit_q       <= phit_d;
      ptaken_q     <= ptaken_d;
      ptgt_q       <= ptgt_d;
    end
  end

  assign upd_ack          = upd_ack_q;
  assign upd_prev_counter = prev_cnt_q;
  assign upd_prev_valid   = prev_valid_q;
  assign pred_valid       = pv_q;
  assign pred_pc          = ppc_q;
  assign pred_hit         = phit_q;
  assign pred_taken       = ptaken_q;
  assign pred_target      = ptgt_q;

endmodule

// File: tb/tb_bht_btb_lookup.sv
// Directed bench for bht_btb_lookup: a bench-side table RAM, a transaction-level
// reference model checked every cycle, and literal expectations from hand decoding.
module tb_bht_btb_lookup;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_valid, stall, upd_req, mem_wr_en;
  logic [10:0] fetch_pc, upd_pc;
  logic [5:0]  mem_wr_addr;
  logic [31:0] mem_rd_data, mem_wr_data;
  logic        fetch_ready, upd_ack, upd_prev_valid, mem_rd_en;
  logic        pred_valid, pred_hit, pred_taken;
  logic [1:0]  upd_prev_counter;
  logic [5:0]  mem_rd_addr;
  logic [10:0] pred_pc, pred_target;

  bht_btb_lookup #(.PC_BITS(11), .INDEX_BITS(6), .TAG_BITS(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .fetch_ready(fetch_ready),
    .stall(stall),
    .upd_req(upd_req), .upd_pc(upd_pc), .upd_ack(upd_ack),
    .upd_prev_counter(upd_prev_counter), .upd_prev_valid(upd_prev_valid),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_hit(pred_hit),
    .pred_taken(pred_taken), .pred_target(pred_target)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [31:0] mem [64];

  // Model: kind of read outstanding (0 none, 1 fetch, 2 update), its PC, fairness flag.
  int          m_kind;
  logic [10:0] m_pc;
  bit          m_upd_first;
  logic        e_ack, e_pvalid, e_pv, e_phit, e_ptaken;
  logic [1:0]  e_pcnt;
  logic [10:0] e_ppc, e_ptgt;

  logic        s_en, s_fr;
  logic [5:0]  s_addr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_kind = 0; m_pc = '0; m_upd_first = 1'b1;
    e_ack = 0; e_pvalid = 0; e_pcnt = 0; e_pv = 0; e_ppc = 0; e_phit = 0; e_ptaken = 0; e_ptgt = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".rd_en"}, mem_rd_en, 0);
    chk({tag, ".rd_addr"}, mem_rd_addr, 0);
    chk({tag, ".fetch_ready"}, fetch_ready, 0);
    chk({tag, ".upd_ack"}, upd_ack, 0);
    chk({tag, ".prev_cnt"}, upd_prev_counter, 0);
    chk({tag, ".prev_valid"}, upd_prev_valid, 0);
    chk({tag, ".pred_valid"}, pred_valid, 0);
    chk({tag, ".pred_pc"}, pred_pc, 0);
    chk({tag, ".pred_hit"}, pred_hit, 0);
    chk({tag, ".pred_taken"}, pred_taken, 0);
    chk({tag, ".pred_target"}, pred_target, 0);
  endtask

  task automatic tick();
    int          nk;
    logic [10:0] npc;
    logic [31:0] w;
    logic        h;
    logic [1:0]  c;
    bit          ucand;
    @(negedge clk);
    ucand = upd_req && (m_kind != 2) && !e_ack;
    nk = 0;
    npc = '0;
    if (!stall) begin
      if (ucand && (!fetch_valid || m_upd_first)) begin nk = 2; npc = upd_pc; end
      else if (fetch_valid) begin nk = 1; npc = fetch_pc; end
    end
    chk("rd_en", mem_rd_en, (nk != 0));
    chk("rd_addr", mem_rd_addr, (nk != 0) ? (npc % 64) : 0);
    chk("fetch_ready", fetch_ready, (nk == 1));
    chk("upd_ack", upd_ack, e_ack);
    if (e_ack) begin
      chk("prev_cnt", upd_prev_counter, e_pcnt);
      chk("prev_valid", upd_prev_valid, e_pvalid);
    end
    chk("pred_valid", pred_valid, e_pv);
    if (e_pv) begin
      chk("pred_pc", pred_pc, e_ppc);
      chk("pred_hit", pred_hit, e_phit);
      chk("pred_taken", pred_taken, e_ptaken);
      chk("pred_target", pred_target, e_ptgt);
    end
    s_en = mem_rd_en; s_addr = mem_rd_addr; s_fr = fetch_ready;

    e_ack = (m_kind == 2);
    if (m_kind != 0) begin
      w = (mem_wr_en && mem_wr_addr == (m_pc % 64)) ? mem_wr_data : mem_rd_data;
      h = w[16] && (w[15:11] == (m_pc >> 6));
      c = w[18:17];
      if (m_kind == 2) begin
        e_pcnt = h ? c : 2'd1;
        e_pvalid = h;
      end else begin
        e_pv = 1; e_ppc = m_pc; e_phit = h;
        e_ptaken = h && (c >= 2);
        e_ptgt = e_ptaken ? w[10:0] : 11'((m_pc + 1) % 2048);
      end
    end
    if (m_kind != 1 && !stall) e_pv = 0;
    m_kind = nk;
    if (nk != 0) begin m_pc = npc; m_upd_first = (nk == 1); end

    @(posedge clk);
    #1;
    if (s_en) mem_rd_data = mem[s_addr];
    if (mem_wr_en) mem[mem_wr_addr] = mem_wr_data;
  endtask

  initial begin
    rst_n = 0; fetch_valid = 0; fetch_pc = 0; stall = 0; upd_req = 0; upd_pc = 0;
    mem_wr_en = 0; mem_wr_addr = 0; mem_wr_data = 0; mem_rd_data = 0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    model_reset();
    #12;
    chk_all_zero("reset");
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;

    // Hit, counter 11, tag 01, target 0x033
    mem[5] = 32'h0007_0833;
    fetch_valid = 1; fetch_pc = 11'h045; tick();
    chk("t1.addr", s_addr, 6'h05);
    fetch_valid = 0; tick();
    chk("t1.hit", pred_hit, 1); chk("t1.taken", pred_taken, 1); chk("t1.tgt", pred_target, 11'h033);
    tick();
    chk("t1.clear", pred_valid, 0);

    // Counter 01 hit, tag alias, wrap at 0x7FF; issued back to back
    mem[5] = 32'h0003_0833;
    fetch_valid = 1; fetch_pc = 11'h045; tick();
    fetch_pc = 11'h085; tick();
    chk("t2.hit", pred_hit, 1); chk("t2.taken", pred_taken, 0); chk("t2.tgt", pred_target, 11'h046);
    fetch_pc = 11'h7FF; tick();
    chk("t3.pv", pred_valid, 1); chk("t3.hit", pred_hit, 0); chk("t3.tgt", pred_target, 11'h086);
    fetch_valid = 0; tick();
    chk("t4.pv", pred_valid, 1); chk("t4.hit", pred_hit, 0); chk("t4.tgt", pred_target, 11'h000);
    tick();

    // Forwarding: RAM still returns counter 00, snooped write carries counter 11
    mem[7] = 32'h0001_0811;
    fetch_valid = 1; fetch_pc = 11'h047; tick();
    fetch_valid = 0; mem_wr_en = 1; mem_wr_addr = 6'h07; mem_wr_data = 32'h0007_0822; tick();
    mem_wr_en = 0;
    chk("fwd.taken", pred_taken, 1); chk("fwd.tgt", pred_target, 11'h022);
    tick();

    // Arbitration: UPD first, then FETCH twice; one ack with counter 11
    mem[5] = 32'h0007_0833;
    upd_req = 1; upd_pc = 11'h045; fetch_valid = 1; fetch_pc = 11'h047; tick();
    chk("arb.c0.fr", s_fr, 0); chk("arb.c0.addr", s_addr, 6'h05);
    tick();
    chk("arb.c1.fr", s_fr, 1); chk("arb.c1.addr", s_addr, 6'h07);
    chk("arb.ack", upd_ack, 1); chk("arb.cnt", upd_prev_counter, 2'b11); chk("arb.pvld", upd_prev_valid, 1);
    upd_req = 0; tick();
    chk("arb.c2.fr", s_fr, 1); chk("arb.ack_off", upd_ack, 0);
    fetch_valid = 0; tick(); tick();

    // Update miss on tag alias
    upd_req = 1; upd_pc = 11'h0C5; tick(); tick();
    chk("miss.ack", upd_ack, 1); chk("miss.cnt", upd_prev_counter, 2'b01); chk("miss.pvld", upd_prev_valid, 0);
    upd_req = 0; tick(); tick();

    // Stall one cycle after a fetch issue: result lands and holds
    fetch_valid = 1; fetch_pc = 11'h045; tick();
    stall = 1; tick();
    chk("stall.en", s_en, 0); chk("stall.pv", pred_valid, 1); chk("stall.tgt", pred_target, 11'h033);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall.hold_en", s_en, 0); chk("stall.hold_pv", pred_valid, 1); chk("stall.hold_tgt", pred_target, 11'h033);
    end
    stall = 0; fetch_valid = 0; tick(); tick();
    chk("stall.after", pred_valid, 0);

    // Reset with an update read in flight
    fetch_valid = 1; fetch_pc = 11'h047; tick();
    upd_req = 1; upd_pc = 11'h045; fetch_valid = 0; tick();
    upd_req = 0; rst_n = 0; #1;
    chk_all_zero("midrst");
    model_reset();
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    chk("midrst.no_ack", upd_ack, 0);
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
